// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared FSM state type and shift-direction constants.
//   state_t   : IDLE (accepting commands) / SHIFT (multi-cycle shift running)
//   DIR_LEFT  : shift toward the MSB
//   DIR_RIGHT : shift toward the LSB
package shift_reg_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;
endpackage

// File: rtl/shift_reg_lr_core.sv
// shift_reg_lr_core: combinational single-bit left/right shift step.
//   data      in  : current register value
//   dir       in  : DIR_LEFT or DIR_RIGHT
//   fill      in  : bit entering the vacated position
//   next_data out : shifted value
//   out_bit   out : bit leaving the register (MSB for left, LSB for right)
module shift_reg_lr_core
    import shift_reg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    input  logic         dir,
    input  logic         fill,
    output logic [W-1:0] next_data,
    output logic         out_bit
);
    always_comb begin
        next_data = (dir == DIR_LEFT) ? {data[W-2:0], fill} : {fill, data[W-1:1]};
        out_bit   = (dir == DIR_LEFT) ? data[W-1] : data[0];
    end
endmodule

// File: rtl/shift_reg_lr_load.sv
// shift_reg_lr_load: loadable register with multi-cycle left/right shift, one bit per clock.
//   clk, reset_n (sync, active-low)
//   cmd_valid/cmd_ready : command handshake, accepted only in IDLE
//   load, shift_left_right, data_in, shift_amt : command fields sampled at acceptance
//   serial_in  : fill bit, sampled on each shift edge
//   data_out, serial_out, busy, done : register, last bit out, shift running, completion pulse
//   Optional macro SHIFT_REG_ROTATE_EN adds input rotate (fill = outgoing bit).
module shift_reg_lr_load
    import shift_reg_pkg::*;
#(
    parameter int REG_WIDTH = 8,
    localparam int SHAMT_W = $clog2(REG_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 load,
    input  logic                 shift_left_right,
    input  logic [REG_WIDTH-1:0] data_in,
    input  logic [SHAMT_W-1:0]   shift_amt,
    input  logic                 serial_in,
`ifdef SHIFT_REG_ROTATE_EN
    input  logic                 rotate,
`endif
    output logic [REG_WIDTH-1:0] data_out,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 done
);
    state_t               state, state_next;
    logic [SHAMT_W-1:0]   count, amt_c;
    logic                 dir, fill, out_bit, accept;
    logic [REG_WIDTH-1:0] next_data;
`ifdef SHIFT_REG_ROTATE_EN
    logic                 rot;
`endif

    shift_reg_lr_core #(.W(REG_WIDTH)) u_core (
        .data      (data_out),
        .dir       (dir),
        .fill      (fill),
        .next_data (next_data),
        .out_bit   (out_bit)
    );

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state == SHIFT);
        accept    = cmd_valid && cmd_ready;
        amt_c     = (shift_amt > SHAMT_W'(REG_WIDTH)) ? SHAMT_W'(REG_WIDTH) : shift_amt;
`ifdef SHIFT_REG_ROTATE_EN
        // Outgoing bit is derived from data_out directly to keep the core free of a feedback path.
        fill = rot ? ((dir == DIR_LEFT) ? data_out[REG_WIDTH-1] : data_out[0]) : serial_in;
`else
        fill = serial_in;
`endif
        state_next = state;
        if (state == IDLE)
            state_next = (accept && !load && amt_c != '0) ? SHIFT : IDLE;
        else
            state_next = (count == SHAMT_W'(1)) ? IDLE : SHIFT;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out   <= '0;
            serial_out <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            dir        <= DIR_RIGHT;
`ifdef SHIFT_REG_ROTATE_EN
            rot        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == SHIFT) begin
                data_out   <= next_data;
                serial_out <= out_bit;
                count      <= count - SHAMT_W'(1);
                done       <= (count == SHAMT_W'(1));
            end else if (accept) begin
                if (load) begin
                    data_out <= data_in;
                    done     <= 1'b1;
                end else begin
                    dir   <= shift_left_right;
                    count <= amt_c;
                    done  <= (amt_c == '0);
`ifdef SHIFT_REG_ROTATE_EN
                    rot   <= rotate;
`endif
                end
            end
        end
    end
endmodule
